// File: rtl/branch_resolver_if.sv
// Execute-stage branch bus: ID/EX branch operands in, fetch redirect and flush control out.
interface branch_resolver_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
);
  logic             br_valid;
  logic [1:0]       br_op;
  logic [1:0]       cmp_result;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  offset;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  target;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output br_valid, br_op, cmp_result, pc, offset, stall,
    input  redirect, target, flush, busy, taken_count
  );

  modport slave (
    input  br_valid, br_op, cmp_result, pc, offset, stall,
    output redirect, target, flush, busy, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves branches from the comparator result: one-cycle redirect pulse, a fixed-length
// flush window, and a saturating taken-branch counter. All outputs come from registers.
module branch_resolver #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input logic               clk,
  input logic               rst,
  branch_resolver_if.slave  bus
);
  localparam int FCNT_W = 4;
  localparam logic [FCNT_W-1:0]      FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic signed [PC_W-1:0] ONE_S     = PC_W'(1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [FCNT_W-1:0]       r_fcnt, w_fcnt_nxt;
  logic                    r_redirect_p1, w_redirect_p0;
  logic [PC_W-1:0]         r_target_p1, w_target_p0;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic signed [PC_W-1:0]  w_pc_s, w_off_s, w_sum_s;

  function automatic logic branch_taken(input logic [1:0] op, input logic [1:0] cmp);
    case (op)
      2'b00:   return cmp == 2'b00;
      2'b01:   return cmp == 2'b01;
      2'b10:   return cmp == 2'b10;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Target wraps modulo 2^PC_W; the signed view only documents that offset is two's complement.
  assign w_pc_s  = $signed(bus.pc);
  assign w_off_s = $signed(bus.offset);
  assign w_sum_s = w_pc_s + w_off_s + ONE_S;

  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_redirect_p0 = 1'b0;
    w_target_p0   = r_target_p1;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.br_valid && !bus.stall && branch_taken(bus.br_op, bus.cmp_result)) begin
          w_redirect_p0 = 1'b1;
          w_target_p0   = $unsigned(w_sum_s);
          w_state_nxt   = FLUSH;
          w_fcnt_nxt    = FCNT_INIT;
          w_cnt_nxt     = sat_inc(r_cnt);
        end
      end
      FLUSH: begin
        // br_valid is ignored here: that instruction is being squashed
        if (r_fcnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
    endcase
  end

  // ---- stage p0 -> p1: resolution results registered ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_fcnt        <= '0;
      r_redirect_p1 <= 1'b0;
      r_target_p1   <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_redirect_p1 <= w_redirect_p0;
      r_target_p1   <= w_target_p0;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign bus.redirect    = r_redirect_p1;
  assign bus.target      = r_target_p1;
  assign bus.flush       = (r_state == FLUSH);
  assign bus.busy        = (r_state == FLUSH);
  assign bus.taken_count = r_cnt;
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized plus directed bench for branch_resolver with a queue-based scoreboard.
module tb_branch_resolver;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.PC_W(16), .CNT_W(8)) bus ();

  branch_resolver #(.PC_W(16), .FLUSH_CYCLES(FC), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int e_idx;
    int tgt;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   last_taken = -1000;
  int   m_cnt    = 0;
  int   m_tgt    = 0;
  bit   m_flush  = 1'b0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp_v, edge_n);
    end
  endtask

  function automatic bit ref_taken(input logic [1:0] op, input logic [1:0] cmp);
    // BEQ=0 needs equal(0), BLT=1 needs less(1), BGT=2 needs greater(2), JMP=3 always
    if (op == 2'd3) return 1'b1;
    if (cmp == 2'd3) return 1'b0;
    return int'(op) == int'(cmp);
  endfunction

  function automatic int ref_target(input logic [15:0] p, input logic [15:0] o);
    int off_i;
    int t;
    off_i = int'(o);
    if (off_i >= 32768) off_i = off_i - 65536;
    t = int'(p) + 1 + off_i;
    return ((t % 65536) + 65536) % 65536;
  endfunction

  // Reference model: an accepted taken branch at edge e blocks acceptance until edge e+FC+1
  // and keeps flush high for the FC cycles following edges e .. e+FC-1.
  task automatic model_edge();
    edge_n++;
    if (rst) begin
      last_taken = -1000;
      m_cnt      = 0;
      m_tgt      = 0;
    end else if (bus.br_valid && !bus.stall && edge_n >= last_taken + FC + 1 &&
                 ref_taken(bus.br_op, bus.cmp_result)) begin
      last_taken = edge_n;
      m_cnt      = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_tgt      = ref_target(bus.pc, bus.offset);
      q.push_back('{e_idx: edge_n, tgt: m_tgt, cnt: m_cnt});
    end
    m_flush = (edge_n - last_taken) < FC;
  endtask

  task automatic cycle(input logic v, input logic [1:0] op, input logic [1:0] cmp,
                       input logic [15:0] p, input logic [15:0] o,
                       input logic st, input logic r);
    bus.br_valid   = v;
    bus.br_op      = op;
    bus.cmp_result = cmp;
    bus.pc         = p;
    bus.offset     = o;
    bus.stall      = st;
    rst            = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a redirect; checks state every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.redirect) begin
        if (q.size() == 0) begin
          chk("unexpected_redirect", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("redirect_edge", edge_n, e.e_idx);
          chk("redirect_target", int'(bus.target), e.tgt);
          chk("redirect_count", int'(bus.taken_count), e.cnt);
        end
      end else if (q.size() > 0 && q[0].e_idx <= edge_n) begin
        chk("missing_redirect", 0, 1);
        void'(q.pop_front());
      end
      chk("flush", int'(bus.flush), int'(m_flush));
      chk("busy", int'(bus.busy), int'(m_flush));
      chk("taken_count", int'(bus.taken_count), m_cnt);
      chk("target_hold", int'(bus.target), m_tgt);
    end
  end

  initial begin
    bus.br_valid = 1'b0; bus.br_op = 2'd0; bus.cmp_result = 2'd0;
    bus.pc = 16'h0; bus.offset = 16'h0; bus.stall = 1'b0;

    // Reset with a JMP pending
    cycle(1'b1, 2'd3, 2'd0, 16'h1234, 16'h0001, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b1, 2'd3, 2'd0, 16'h1234, 16'h0001, 1'b0, 1'b1);
    chk("rst_redirect", int'(bus.redirect), 0);
    chk("rst_flush", int'(bus.flush), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_target", int'(bus.target), 0);
    chk("rst_count", int'(bus.taken_count), 0);
    idle(2);
    chk("post_rst_flush", int'(bus.flush), 0);

    // BEQ taken
    cycle(1'b1, 2'd0, 2'd0, 16'h0010, 16'h0005, 1'b0, 1'b0);
    chk("beq_redirect", int'(bus.redirect), 1);
    chk("beq_target", int'(bus.target), 16'h0016);
    chk("beq_flush1", int'(bus.flush), 1);
    idle(1);
    chk("beq_redirect_off", int'(bus.redirect), 0);
    chk("beq_flush2", int'(bus.flush), 1);
    idle(1);
    chk("beq_flush_end", int'(bus.flush), 0);
    chk("beq_count", int'(bus.taken_count), 1);

    // BLT with negative offset wrapping below zero, then BGT not taken
    cycle(1'b1, 2'd1, 2'd1, 16'h0004, 16'hFFF8, 1'b0, 1'b0);
    chk("blt_target", int'(bus.target), 16'hFFFD);
    idle(2);
    cycle(1'b1, 2'd2, 2'd0, 16'h0100, 16'h0010, 1'b0, 1'b0);
    chk("bgt_nt_redirect", int'(bus.redirect), 0);
    chk("bgt_nt_flush", int'(bus.flush), 0);
    chk("bgt_nt_count", int'(bus.taken_count), 2);

    // Invalid compare result, then JMP wrapping past 0xFFFF
    cycle(1'b1, 2'd0, 2'd3, 16'h0200, 16'h0004, 1'b0, 1'b0);
    chk("beq_inv_redirect", int'(bus.redirect), 0);
    cycle(1'b1, 2'd3, 2'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    chk("jmp_redirect", int'(bus.redirect), 1);
    chk("jmp_target", int'(bus.target), 16'h0000);
    idle(2);

    // Stall blocks acceptance
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd0, 2'd0, 16'h0040, 16'h0002, 1'b1, 1'b0);
      chk("stall_no_redirect", int'(bus.redirect), 0);
    end
    cycle(1'b1, 2'd0, 2'd0, 16'h0040, 16'h0002, 1'b0, 1'b0);
    chk("unstall_redirect", int'(bus.redirect), 1);
    chk("unstall_target", int'(bus.target), 16'h0043);
    // Taken branch held through both flush cycles, accepted in the first IDLE cycle
    cycle(1'b1, 2'd3, 2'd0, 16'h0500, 16'h0010, 1'b0, 1'b0);
    chk("mask_flush1", int'(bus.redirect), 0);
    cycle(1'b1, 2'd3, 2'd0, 16'h0500, 16'h0010, 1'b0, 1'b0);
    chk("mask_final", int'(bus.redirect), 0);
    chk("mask_final_flush", int'(bus.flush), 0);
    cycle(1'b1, 2'd3, 2'd0, 16'h0500, 16'h0010, 1'b0, 1'b0);
    chk("first_idle_accept", int'(bus.redirect), 1);
    chk("first_idle_target", int'(bus.target), 16'h0511);
    idle(FC + 1);

    // Counter saturation
    for (int i = 0; i < 300 * (FC + 1); i++)
      cycle(1'b1, 2'd3, 2'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    idle(FC + 1);
    chk("sat_count", int'(bus.taken_count), 255);

    // Reset in the middle of a flush window
    cycle(1'b1, 2'd3, 2'd0, 16'h0800, 16'h0001, 1'b0, 1'b0);
    chk("pre_rst_flush", int'(bus.flush), 1);
    chk("pre_rst_count", int'(bus.taken_count), 255);
    idle(0);
    cycle(1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("mid_rst_flush", int'(bus.flush), 0);
    chk("mid_rst_count", int'(bus.taken_count), 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    idle(FC + 2);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits directly downstream of the 16-bit signed comparator in the execute stage.
- Consumes the 2-bit compare result plus branch opcode, PC and offset from the ID/EX register, and decides taken/not-taken.
- On a taken branch it issues a one-cycle PC redirect and holds a pipeline flush for a fixed number of cycles.
- Keeps a saturating count of taken branches for debug.

Parameters:
- PC_W, 16: width of PC, offset and target.
- FLUSH_CYCLES, 2: number of cycles flush is held after a taken branch. Legal range is 1 to 15.
- CNT_W, 8: width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- br_valid  input  1  a branch/jump instruction is present in EX this cycle.
- br_op  input  2  00 BEQ, 01 BLT, 10 BGT, 11 JMP (unconditional).
- cmp_result  input  2  comparator output for in1 vs in2 (signed): 00 equal, 01 in1<in2, 10 in1>in2, 11 invalid.
- pc  input  PC_W  word address of the branch instruction.
- offset  input  PC_W  signed word offset, two's complement.
- stall  input  1  pipeline stall; blocks acceptance of br_valid.
- redirect  output  1  one-cycle pulse: fetch must load target.
- target  output  PC_W  branch target; meaningful only when redirect=1.
- flush  output  1  squash IF/ID and ID/EX contents.
- busy  output  1  resolver is in FLUSH state.
- taken_count  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: synchronous, when rst=1 at a rising edge.
  - state=IDLE.
  - redirect=0, target=0, flush=0, busy=0, taken_count=0.
  - Reset overrides everything, including mid-FLUSH; flush drops the cycle after the reset edge.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, FLUSH. A down-counter fcnt is sized to hold FLUSH_CYCLES.
- IDLE acceptance: a branch is accepted when br_valid=1 and stall=0. If stall=1, br_valid is ignored and nothing changes; upstream holds the instruction.
- Taken decision for an accepted branch:
  - BEQ is taken iff cmp_result=00.
  - BLT is taken iff cmp_result=01.
  - BGT is taken iff cmp_result=10.
  - JMP is always taken, regardless of cmp_result.
  - cmp_result=11 makes every conditional op not-taken.
- Accepted and taken (at the next edge):
  - redirect=1 and flush=1 for that cycle.
  - target = pc + 1 + offset, computed modulo 2^PC_W; wrap-around is silent.
  - state goes to FLUSH with fcnt=FLUSH_CYCLES-1.
  - taken_count increments, saturating at all-ones.
  - Latency from acceptance edge to redirect: 1 cycle.
- Accepted and not-taken: no output changes; state stays IDLE.
- FLUSH state:
  - flush=1 and busy=1; redirect=0 after its single pulse.
  - fcnt decrements every cycle; stall has no effect on it.
  - When fcnt=0, the next edge returns to IDLE with flush=0 and busy=0.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles, starting with the redirect cycle.
  - FLUSH_CYCLES=1: the FLUSH state lasts zero extra cycles; return to IDLE the edge after the redirect cycle.
- br_valid is ignored in FLUSH, including in the final flush cycle, because that instruction is being squashed. The first acceptable br_valid is in the first IDLE cycle.
- Back-to-back branches: the earliest a second taken branch can redirect is FLUSH_CYCLES+1 cycles after the first redirect.
- target holds its last value when redirect=0.

Test Plan:
- Reset check: assert rst for 2 cycles with br_valid=1, br_op=11 → all outputs 0 and taken_count=0. After release, with br_valid=0, outputs stay 0.
- BEQ taken: pc=0x0010, offset=0x0005, cmp_result=00, br_op=00, br_valid=1 for one cycle → next cycle redirect=1, target=0x0016, flush=1. flush stays high for exactly 2 cycles total; taken_count=1.
- Signed/negative offset and wrap: BLT with cmp_result=01, pc=0x0004, offset=0xFFF8 → target=0xFFFD. Then BGT with cmp_result=00 → no redirect, no flush, taken_count unchanged.
- Invalid result and JMP: BEQ with cmp_result=11 → not taken. JMP with cmp_result=11, pc=0xFFFF, offset=0x0000 → taken, target=0x0000.
- Stall and FLUSH masking:
  - BEQ taken presented with stall=1 for 3 cycles → no action. Drop stall → redirect on the next cycle.
  - A second taken br_valid during both flush cycles → ignored.
  - The same branch held into the first IDLE cycle → accepted, second redirect.
- Saturation and mid-flush reset: 260 taken JMPs → taken_count=0xFF. Then rst asserted during a flush cycle → flush=0 on the next cycle and taken_count=0.
